// File: rtl/pll_pkg.sv
// Shared PLL loop-filter constants: word widths, proportional gain, DCO midscale, shift and run length.
package pll_pkg;
  localparam int IW      = 20;
  localparam int OW      = 10;
  localparam int KP      = 64;
  localparam int DCO_MID = 1 << (OW - 1);
  localparam int SHIFT   = IW - OW;
  localparam int RUN_LEN = 4;
endpackage

// File: rtl/pi_loop_filter_lock_detect.sv
// Bang-bang lock detector: counts x toggles toward lock, and a run of equal samples drops lock.
// Advances only on en cycles; locked is registered from the next-state toggle count.
module lock_detect
  import pll_pkg::*;
#(
  parameter int LOCK_CNT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic x,
  output logic locked
);
  localparam int TW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(RUN_LEN + 1);
  localparam logic [TW-1:0] TMAX = TW'(LOCK_CNT);
  localparam logic [RW-1:0] RMAX = RW'(RUN_LEN);

  logic          r_prev;
  logic          r_locked;
  logic [TW-1:0] r_tcnt;
  logic [TW-1:0] w_tcnt;
  logic [RW-1:0] r_rcnt;
  logic [RW-1:0] w_rcnt;

  always_comb begin
    w_tcnt = r_tcnt;
    w_rcnt = r_rcnt;
    if (x != r_prev) begin
      w_rcnt = '0;
      if (r_tcnt != TMAX) w_tcnt = r_tcnt + 1'b1;
    end else if (r_rcnt != RMAX) begin
      w_rcnt = r_rcnt + 1'b1;
    end
    // A long run of identical decisions means the loop is slewing, not dithering.
    if (w_rcnt == RMAX) w_tcnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev   <= 1'b0;
      r_tcnt   <= '0;
      r_rcnt   <= '0;
      r_locked <= 1'b0;
    end else if (en) begin
      r_prev   <= x;
      r_tcnt   <= w_tcnt;
      r_rcnt   <= w_rcnt;
      r_locked <= (w_tcnt == TMAX);
    end
  end

  assign locked = r_locked;
endmodule

// File: rtl/pi_loop_filter.sv
// PI loop filter: integral word plus +/-KP proportional step, decimated and clipped into a DCO code.
// Code lands 2 clk after the sample taken on the last decimation slot; en low freezes everything.
module pi_loop_filter #(
  parameter int IW       = pll_pkg::IW,
  parameter int OW       = pll_pkg::OW,
  parameter int KP       = pll_pkg::KP,
  parameter int DECIM    = 8,
  parameter int LOCK_CNT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          x,
  input  logic [IW-1:0] integ,
  output logic [OW-1:0] dco_code,
  output logic          dco_upd,
  output logic          sat_hi,
  output logic          sat_lo,
  output logic          locked
);
  localparam int SH = IW - OW;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic signed [IW+1:0] KP_S  = (IW+2)'(KP);
  localparam logic signed [IW+1:0] MID_S = (IW+2)'(1 << (OW - 1));
  localparam logic signed [IW+1:0] MAX_S = (IW+2)'((1 << OW) - 1);
  localparam logic [OW-1:0]        MID_C = OW'(1 << (OW - 1));
  localparam logic [DW-1:0]        DLAST = DW'(DECIM - 1);

  logic signed [IW+1:0] r_sum;
  logic signed [IW+1:0] w_p;
  logic signed [IW+1:0] w_sum_nxt;
  logic signed [IW+1:0] w_code;
  logic [OW-1:0]        w_code_clip;
  logic                 w_hi;
  logic                 w_lo;
  logic [DW-1:0]        r_dcnt;
  logic                 r_pend;
  logic [OW-1:0]        r_code;
  logic                 r_upd;
  logic                 r_hi;
  logic                 r_lo;
  logic                 w_locked;

  always_comb begin
    w_p       = x ? KP_S : -KP_S;
    w_sum_nxt = $signed({{2{integ[IW-1]}}, integ}) + w_p;
    w_code    = (r_sum >>> SH) + MID_S;
    w_hi      = (w_code > MAX_S);
    w_lo      = w_code[IW+1];
    if (w_hi)      w_code_clip = '1;
    else if (w_lo) w_code_clip = '0;
    else           w_code_clip = w_code[OW-1:0];
  end

  // r_pend marks that r_sum holds the last sample of a window; the code loads on the next en cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_dcnt <= '0;
      r_pend <= 1'b0;
      r_code <= MID_C;
      r_upd  <= 1'b0;
      r_hi   <= 1'b0;
      r_lo   <= 1'b0;
    end else if (en) begin
      r_sum  <= w_sum_nxt;
      r_dcnt <= (r_dcnt == DLAST) ? '0 : r_dcnt + 1'b1;
      r_pend <= (r_dcnt == DLAST);
      r_upd  <= r_pend;
      if (r_pend) begin
        r_code <= w_code_clip;
        r_hi   <= w_hi;
        r_lo   <= w_lo;
      end
    end else begin
      r_upd <= 1'b0;
    end
  end

  lock_detect #(
    .LOCK_CNT(LOCK_CNT)
  ) u_lock (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .x      (x),
    .locked (w_locked)
  );

  assign dco_code = r_code;
  assign dco_upd  = r_upd;
  assign sat_hi   = r_hi;
  assign sat_lo   = r_lo;
  assign locked   = w_locked;
endmodule
